// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV M-extension multiply/divide unit (MULDIV_FAST_MUL_EN
//               selects a single-cycle multiplier). Revision 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int            CW        = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          func_q, func_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic                neg_q, neg_d;
   logic                rneg_q, rneg_d;
   logic [XLEN-1:0]     result_q, result_d;

   // Operand conditioning at accept: signed operands are reduced to magnitudes
   logic            w_a_signed, w_b_signed, w_a_sgn, w_b_sgn;
   logic [XLEN-1:0] w_a_mag, w_b_mag;

   assign w_a_signed = func3[2] ? ~func3[0] : ((func3[1:0] == 2'b01) || (func3[1:0] == 2'b10));
   assign w_b_signed = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01);
   assign w_a_sgn    = w_a_signed & op_a[XLEN-1];
   assign w_b_sgn    = w_b_signed & op_b[XLEN-1];
   assign w_a_mag    = w_a_sgn ? -op_a : op_a;
   assign w_b_mag    = w_b_sgn ? -op_b : op_b;

   // Shift-add multiply: acc holds {partial high, remaining multiplier bits}
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_mul_next, w_mul_fin;
   logic [XLEN-1:0]   w_mul_res;

   assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                       (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
   assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
   assign w_mul_fin  = neg_q ? -w_mul_next : w_mul_next;
   assign w_mul_res  = (func_q[1:0] == 2'b00) ? w_mul_fin[XLEN-1:0] : w_mul_fin[2*XLEN-1:XLEN];

   // Restoring divide: acc holds {partial remainder, dividend/quotient bits}
   logic [XLEN:0]   w_div_shift, w_div_trial;
   logic            w_div_ok;
   logic [XLEN-1:0] w_rem_next, w_quo_next, w_rem_fin, w_quo_fin;

   assign w_div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign w_div_trial = w_div_shift - {1'b0, opnd_q};
   assign w_div_ok    = ~w_div_trial[XLEN];
   assign w_rem_next  = w_div_ok ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0];
   assign w_quo_next  = {acc_q[XLEN-2:0], w_div_ok};
   assign w_rem_fin   = rneg_q ? -w_rem_next : w_rem_next;
   assign w_quo_fin   = neg_q ? -w_quo_next : w_quo_next;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fast_raw, w_fast_prod;
   logic [XLEN-1:0]   w_fast_res;

   assign w_fast_raw  = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
   assign w_fast_prod = (w_a_sgn ^ w_b_sgn) ? -w_fast_raw : w_fast_raw;
   assign w_fast_res  = (func3[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`endif

   always_comb begin
      state_d  = state_q;
      func_d   = func_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               func_d = func3;
               cnt_d  = '0;
               neg_d  = w_a_sgn ^ w_b_sgn;
               rneg_d = w_a_sgn;
               if (func3[2]) begin
                  if (op_b == '0) begin
                     result_d = func3[1] ? op_a : ALL_ONES;
                     state_d  = DONE;
                  end else if (!func3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES)) begin
                     result_d = func3[1] ? '0 : op_a;
                     state_d  = DONE;
                  end else begin
                     acc_d   = {{XLEN{1'b0}}, w_a_mag};
                     opnd_d  = w_b_mag;
                     state_d = DIV;
                  end
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  result_d = w_fast_res;
                  state_d  = DONE;
`else
                  acc_d   = {{XLEN{1'b0}}, w_b_mag};
                  opnd_d  = w_a_mag;
                  state_d = MUL;
`endif
               end
            end
         end
         MUL: begin
            acc_d = w_mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               result_d = w_mul_res;
               state_d  = DONE;
            end
         end
         DIV: begin
            acc_d = {w_rem_next, w_quo_next};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               result_d = func_q[1] ? w_rem_fin : w_quo_fin;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         func_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         func_q   <= func_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : vector table + scoreboard bench for muldiv_unit (XLEN=32)
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  func3;
   logic [31:0] op_a, op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .func3     (func3),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      int          hold;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, p;
      logic [63:0]        up;
      logic               ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ub  = {32'b0, b};
      up  = {32'b0, a} * {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: return up[31:0];
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: return up[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sb;
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return MUL_LAT;
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return DIV_LAT;
   endfunction

   task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
      int          n;
      int          edges;
      logic [31:0] want;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " in_ready before accept"}, in_ready, 1);
      func3    = f;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
      func3    = 3'($urandom);
      chk({nm, " busy"}, busy, 1);
      edges = 1;
      while (!out_valid && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk({nm, " out_valid"}, out_valid, 1);
      chk({nm, " latency"}, edges, lat);
      want = sb.pop_front();
      chk({nm, " result"}, result, want);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({nm, " hold out_valid"}, out_valid, 1);
         chk({nm, " hold result"}, result, want);
         chk({nm, " hold in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, " idle out_valid"}, out_valid, 0);
      chk({nm, " idle in_ready"}, in_ready, 1);
      chk({nm, " idle busy"}, busy, 0);
   endtask

   initial begin
      int          pulses;
      logic [2:0]  rf;
      logic [31:0] ra, rb;

      vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0};
      vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0};
      vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 0};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, 0};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT, 0};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT, 0};
      vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT, 5};
      vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         DIV_LAT, 0};
      vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,       0};
      vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1,       0};
      vecs[10] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,       0};
      vecs[11] = '{3'd7, 32'd5,         32'd0,         32'd5,         1,       0};
      vecs[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,       0};
      vecs[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,       0};
      vecs[14] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0};
      vecs[15] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT, 0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      func3     = '0;
      op_a      = '0;
      op_b      = '0;
      #12;
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready after reset", in_ready, 1);

      for (int i = 0; i < 16; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
               vecs[i].exp, vecs[i].lat, vecs[i].hold);
      end

      for (int i = 0; i < 12; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         do_op($sformatf("rand%0d", i), rf, ra, rb, ref_res(rf, ra, rb), ref_lat(rf, ra, rb), 0);
      end

      // Abort a signed divide mid-iteration
      @(negedge clk);
      func3    = 3'd4;
      op_a     = 32'hFFFF_FFF9;
      op_b     = 32'd2;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort out_valid", out_valid, 0);
      chk("abort busy", busy, 0);
      chk("abort result", result, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort in_ready", in_ready, 1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      chk("abort no out_valid pulse", pulses, 0);
      do_op("post-reset divu", 3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
